dx_latch: RTL and testbench
===========================

// Module: dx_latch
// PURPOSE
//  Decode/execute pipeline register of the 5-stage core. Captures PC and instruction
//  from the fetch/decode latch, splits the instruction into its fields and presents
//  the raw 17-bit immediate that sign_ex widens for the ALU B mux.
//  Also classifies the instruction type, inserts NOP bubbles on flush, holds on stall
//  and issues a one-cycle start pulse to the multdiv unit.
// PARAMETERS
//  PC_W     32          width of the program counter carried with the instruction
//  NOP_WORD 32'h0000_0000  word loaded on reset or flush (sll $0,$0,0)
// PORTS
//  clock     in   1     rising-edge clock
//  reset     in   1     synchronous, active-high; sampled on clock rising edge
//  stall     in   1     hold all registers (hazard unit)
//  flush     in   1     replace captured word with NOP_WORD (branch/jump taken)
//  pc_in     in   PC_W  PC of the incoming instruction
//  insn_in   in   32    incoming instruction word
//  valid_in  in   1     incoming slot holds a real instruction
//  pc_out    out  PC_W  registered PC
//  insn_out  out  32    registered instruction
//  valid_out out  1     registered valid
//  opcode    out  5     insn_out[31:27]
//  rd        out  5     insn_out[26:22]
//  rs        out  5     insn_out[21:17]
//  rt        out  5     insn_out[16:12]
//  shamt     out  5     insn_out[11:7]
//  aluop     out  5     insn_out[6:2]
//  imm17     out  17    insn_out[16:0]; feeds sign_ex.in
//  target    out  27    insn_out[26:0], zero-extended by the consumer
//  is_r/is_i/is_j out 1 each; type flags decoded from opcode (one-hot or all 0 on NOP)
//  md_start  out  1     one-cycle pulse: R-type mul (aluop 00110) or div (00111) captured
// BEHAVIOUR
//  - Reset: pc_out=0, insn_out=NOP_WORD, valid_out=0, md_start=0; all fields follow insn_out.
//  - Field/flag outputs are combinational from insn_out (zero added latency); capture latency 1 cycle.
//  - Priority per edge: reset > flush > stall > load.
//  - flush: insn_out<=NOP_WORD, valid_out<=0, pc_out<=pc_in, md_start<=0; flush overrides stall.
//  - stall (no flush): every register holds; md_start<=0 (no repeat pulse while held).
//  - load: pc_out<=pc_in, insn_out<=insn_in, valid_out<=valid_in.
//  - valid_in=0: insn captured as NOP_WORD, valid_out=0.
//  - Type decode: opcode 00000 -> is_r; 00101,00111,01000,00010,00110 -> is_i;
//    00001,00011,10101,10110,00100 -> is_j; any other opcode -> all flags 0.
//    NOP (word 0) with valid_out=0 forces all flags 0.
//  - md_start asserted the cycle after a load of a valid R-type mul/div; exactly 1 cycle.
//  - Reset mid-stall or mid-flush: reset wins; state as at reset next cycle.
//  - imm17 is passed unmodified; sign extension is solely sign_ex's job.
// CONFIGURATION
//  DX_STALL_CNT_EN: when defined, adds output stall_cnt [15:0]: counts cycles with
//   stall=1 and flush=0, saturates at 16'hFFFF, clears on reset only.
//   Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset=1 two cycles -> insn_out=0, valid_out=0, pc_out=0, flags all 0, md_start=0.
//  2 load insn 32'h28C3FFFF (addi r3,r1,-1), pc 0x40 -> next cycle opcode=5, rd=3, rs=1,
//    imm17=17'h1FFFF, is_i=1; sign_ex output 32'hFFFFFFFF.
//  3 load 32'h01043018 (mul r4,r2,r3) -> md_start high one cycle; hold stall=1 3 cycles
//    -> insn_out held, md_start stays 0.
//  4 stall=1 and flush=1 same edge with insn 32'h28C3FFFF -> insn_out=0, valid_out=0.
//  5 load valid insn, then reset=1 with stall=1 -> all outputs at reset values next cycle.
//  6 DX_STALL_CNT_EN: stall 5 cycles, 1 of them with flush -> stall_cnt=4; 70000 stall
//    cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/dx_latch.sv
// -----------------------------------------------------------------------------
// dx_latch : decode/execute pipeline register of the 5-stage core.
//
// Captures PC and instruction from the fetch/decode latch, exposes the decoded
// instruction fields and type flags combinationally from the registered word,
// inserts NOP bubbles on flush, holds on stall and emits a one-cycle start
// pulse to the multdiv unit when a valid R-type mul/div is captured.
//
// Optional feature (macro DX_STALL_CNT_EN): adds stall_cnt[15:0], a saturating
// count of cycles with stall=1 and flush=0, cleared only by reset.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   stall, flush         hazard hold / branch-taken bubble insert
//   pc_in, insn_in,      incoming slot (PC, word, valid)
//   valid_in
//   pc_out, insn_out,    registered slot
//   valid_out
//   opcode..aluop        5-bit instruction fields of insn_out
//   imm17, target        raw immediate / jump target of insn_out (no extension)
//   is_r, is_i, is_j     instruction type flags (all 0 for an empty NOP slot)
//   md_start             one-cycle multdiv start pulse
//   stall_cnt            (DX_STALL_CNT_EN only) saturating stall cycle count
// -----------------------------------------------------------------------------
module dx_latch #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     insn_in,
    input  logic            valid_in,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     insn_out,
    output logic            valid_out,
    output logic [4:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      shamt,
    output logic [4:0]      aluop,
    output logic [16:0]     imm17,
    output logic [26:0]     target,
    output logic            is_r,
    output logic            is_i,
    output logic            is_j,
`ifdef DX_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic            md_start
);

    // A valid R-type mul (00110) or div (00111) in the incoming slot.
    logic md_hit;
    assign md_hit = valid_in && (insn_in[31:27] == 5'b00000) &&
                    ((insn_in[6:2] == 5'b00110) || (insn_in[6:2] == 5'b00111));

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_out    <= '0;
            insn_out  <= NOP_WORD;
            valid_out <= 1'b0;
            md_start  <= 1'b0;
        end else if (flush) begin
            // flush wins over stall: the slot becomes a bubble, PC still advances
            pc_out    <= pc_in;
            insn_out  <= NOP_WORD;
            valid_out <= 1'b0;
            md_start  <= 1'b0;
        end else if (stall) begin
            // hold everything, but never repeat the start pulse
            md_start  <= 1'b0;
        end else begin
            pc_out    <= pc_in;
            insn_out  <= valid_in ? insn_in : NOP_WORD;
            valid_out <= valid_in;
            md_start  <= md_hit;
        end
    end

`ifdef DX_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && !flush && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign opcode = insn_out[31:27];
    assign rd     = insn_out[26:22];
    assign rs     = insn_out[21:17];
    assign rt     = insn_out[16:12];
    assign shamt  = insn_out[11:7];
    assign aluop  = insn_out[6:2];
    assign imm17  = insn_out[16:0];
    assign target = insn_out[26:0];

    // Word 0 shares opcode 00000 with R-type; an empty slot must not look like one.
    logic nop_slot;
    assign nop_slot = !valid_out && (insn_out == 32'h0000_0000);

    always_comb begin
        is_r = 1'b0;
        is_i = 1'b0;
        is_j = 1'b0;
        if (!nop_slot) begin
            case (opcode)
                5'b00000:                                  is_r = 1'b1;
                5'b00101, 5'b00111, 5'b01000,
                5'b00010, 5'b00110:                        is_i = 1'b1;
                5'b00001, 5'b00011, 5'b10101,
                5'b10110, 5'b00100:                        is_j = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dx_latch.sv
// -----------------------------------------------------------------------------
// tb_dx_latch : directed scenarios plus randomized traffic for dx_latch, checked
// every cycle against a behavioural slot model kept in the bench.
// -----------------------------------------------------------------------------
module tb_dx_latch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, stall, flush, valid_in;
    logic [31:0] pc_in, insn_in;
    logic [31:0] pc_out, insn_out;
    logic        valid_out, is_r, is_i, is_j, md_start;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [16:0] imm17;
    logic [26:0] target;
`ifdef DX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model of the slot
    logic [31:0] m_pc, m_insn;
    logic        m_valid, m_md;
    int          m_cnt;

    int i_ops[5] = '{5, 7, 8, 2, 6};
    int j_ops[5] = '{1, 3, 21, 22, 4};

    dx_latch #(.PC_W(32), .NOP_WORD(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .pc_in(pc_in), .insn_in(insn_in), .valid_in(valid_in),
        .pc_out(pc_out), .insn_out(insn_out), .valid_out(valid_out),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
        .imm17(imm17), .target(target), .is_r(is_r), .is_i(is_i), .is_j(is_j),
`ifdef DX_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .md_start(md_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {is_r,is_i,is_j} from the opcode tables.
    function automatic logic [2:0] ref_type(input logic [31:0] w, input logic v);
        int op;
        op = int'(w[31:27]);
        if (!v && w == 32'h0) return 3'b000;
        if (op == 0) return 3'b100;
        foreach (i_ops[k]) if (op == i_ops[k]) return 3'b010;
        foreach (j_ops[k]) if (op == j_ops[k]) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic ref_md(input logic [31:0] w);
        int alu;
        alu = int'(w[6:2]);
        return (w[31:27] == 5'd0) && (alu == 6 || alu == 7);
    endfunction

    task automatic check_all();
        logic [2:0] t;
        t = ref_type(m_insn, m_valid);
        chk("pc_out",    pc_out,           m_pc);
        chk("insn_out",  insn_out,         m_insn);
        chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        chk("md_start",  {31'd0, md_start},  {31'd0, m_md});
        chk("fields", {2'd0, opcode, rd, rs, rt, shamt, aluop},
            {2'd0, m_insn[31:27], m_insn[26:22], m_insn[21:17], m_insn[16:12],
             m_insn[11:7], m_insn[6:2]});
        chk("imm17",  {15'd0, imm17},  m_insn & 32'h0001_FFFF);
        chk("target", {5'd0, target},  m_insn & 32'h07FF_FFFF);
        chk("flags",  {29'd0, is_r, is_i, is_j}, {29'd0, t});
`ifdef DX_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
`endif
    endtask

    // One clock: model applies the inputs the DUT saw, then compare.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            m_pc = 0; m_insn = NOP; m_valid = 0; m_md = 0; m_cnt = 0;
        end else begin
            if (stall && !flush && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_pc = pc_in; m_insn = NOP; m_valid = 0; m_md = 0;
            end else if (stall) begin
                m_md = 0;
            end else begin
                m_pc = pc_in; m_valid = valid_in;
                m_insn = valid_in ? insn_in : NOP;
                m_md = valid_in && ref_md(insn_in);
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic [31:0] pc, input logic [31:0] w, input logic v);
        reset = r; stall = s; flush = f; pc_in = pc; insn_in = w; valid_in = v;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:27] = 5'd0;
            1: w[31:27] = 5'(i_ops[$urandom_range(0, 4)]);
            2: w[31:27] = 5'(j_ops[$urandom_range(0, 4)]);
            default: ;
        endcase
        if ($urandom_range(0, 2) == 0) w[6:2] = 5'(6 + $urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) w = 32'h0;
        return w;
    endfunction

    initial begin
        // 1: reset two cycles
        drive(1, 0, 0, 32'h1234, 32'hFFFF_FFFF, 1);
        step(); step();
        chk("rst_insn", insn_out, 32'h0);
        chk("rst_flags", {29'd0, is_r, is_i, is_j}, 32'h0);

        // 2: addi r3,r1,-1
        drive(0, 0, 0, 32'h40, 32'h28C3_FFFF, 1);
        step();
        chk("addi_op",  {27'd0, opcode}, 32'd5);
        chk("addi_rd",  {27'd0, rd},     32'd3);
        chk("addi_rs",  {27'd0, rs},     32'd1);
        chk("addi_imm", {15'd0, imm17},  32'h1FFFF);
        chk("addi_is_i", {31'd0, is_i},  32'd1);
        chk("addi_sext", {{15{imm17[16]}}, imm17}, 32'hFFFF_FFFF);

        // 3: mul pulse then 3-cycle stall
        drive(0, 0, 0, 32'h44, 32'h0104_3018, 1);
        step();
        chk("mul_md", {31'd0, md_start}, 32'd1);
        chk("mul_rt", {27'd0, rt}, 32'd3);
        drive(0, 1, 0, 32'h48, 32'h28C3_FFFF, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_md", {31'd0, md_start}, 32'd0);
            chk("stall_insn", insn_out, 32'h0104_3018);
        end

        // 4: stall and flush together
        drive(0, 1, 1, 32'h4C, 32'h28C3_FFFF, 1);
        step();
        chk("sf_insn",  insn_out, 32'h0);
        chk("sf_valid", {31'd0, valid_out}, 32'd0);

        // 5: valid load, then reset with stall
        drive(0, 0, 0, 32'h50, 32'h0104_301C, 1);
        step();
        drive(1, 1, 0, 32'h54, 32'h28C3_FFFF, 1);
        step();
        chk("rs_pc", pc_out, 32'h0);
        chk("rs_md", {31'd0, md_start}, 32'd0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom, rand_insn(),
                  $urandom_range(0, 4) != 0);
            step();
        end

`ifdef DX_STALL_CNT_EN
        // 6: 5 stall cycles, one with flush -> 4; then saturation
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, k == 2, 32'h60, 32'h28C3_FFFF, 1);
            step();
        end
        chk("cnt4", {16'd0, stall_cnt}, 32'd4);
        drive(0, 1, 0, 32'h64, 32'h28C3_FFFF, 1);
        repeat (70000) @(posedge clock);
        #1;
        chk("cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
